// File: rtl/regbank_wb_arbiter.sv
// Write-back arbiter for the 32x32 register bank: round-robin grant over N_REQ
// producers, registered write port, and a pending-write scoreboard for RAW hazards.
module regbank_wb_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold_i,
  input  logic [N_REQ-1:0]    req_valid_i,
  input  logic [N_REQ*AW-1:0] req_addr_i,
  input  logic [N_REQ*DW-1:0] req_data_i,
  output logic [N_REQ-1:0]    req_ready_o,
  input  logic                sb_set_i,
  input  logic [AW-1:0]       sb_set_addr_i,
  input  logic [AW-1:0]       rs1_addr_i,
  input  logic [AW-1:0]       rs2_addr_i,
  output logic                rs1_busy_o,
  output logic                rs2_busy_o,
  output logic                wr_en_o,
  output logic [AW-1:0]       rd_addr_o,
  output logic [DW-1:0]       data_o,
  output logic [31:0]         pending_o
);

  localparam int unsigned PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned NREG = 32;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    rr_next;
  logic [NREG-1:0]  scoreboard;
  logic [NREG-1:0]  sb_next;
  logic             arb_en;
  logic             grant_any;
  logic [PW-1:0]    grant_idx;
  logic [N_REQ-1:0] grant;
  logic [AW-1:0]    grant_addr;
  logic [DW-1:0]    grant_data;

  assign arb_en = rst_n && !hold_i;

  // Two-pass scan: requesters at or above rr_ptr first, then wrap to the low ones.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (arb_en && !grant_any && req_valid_i[i] && (i >= int'(rr_ptr))) begin
        grant_any = 1'b1;
        grant_idx = PW'(i);
        grant[i]  = 1'b1;
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (arb_en && !grant_any && req_valid_i[i]) begin
        grant_any = 1'b1;
        grant_idx = PW'(i);
        grant[i]  = 1'b1;
      end
    end
  end

  assign req_ready_o = grant;

  // Select the granted payload from the one-hot grant.
  always_comb begin
    grant_addr = '0;
    grant_data = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant[i]) begin
        grant_addr = req_addr_i[i*AW +: AW];
        grant_data = req_data_i[i*DW +: DW];
      end
    end
  end

  // Explicit wrap so non-power-of-two N_REQ never lands on an unused index.
  always_comb begin
    rr_next = rr_ptr;
    if (grant_any) begin
      rr_next = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);
    end
  end

  // Clear on grant, then set from issue so a newer producer wins; x0 never pends.
  always_comb begin
    sb_next = scoreboard;
    if (grant_any) begin
      sb_next[grant_addr] = 1'b0;
    end
    if (sb_set_i) begin
      sb_next[sb_set_addr_i] = 1'b1;
    end
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      scoreboard <= '0;
      wr_en_o    <= 1'b0;
      rd_addr_o  <= '0;
      data_o     <= '0;
    end else begin
      rr_ptr     <= rr_next;
      scoreboard <= sb_next;
      wr_en_o    <= 1'b0;
      if (grant_any && (grant_addr != '0)) begin
        wr_en_o   <= 1'b1;
        rd_addr_o <= grant_addr;
        data_o    <= grant_data;
      end
    end
  end

  assign rs1_busy_o = (rs1_addr_i != '0) && scoreboard[rs1_addr_i];
  assign rs2_busy_o = (rs2_addr_i != '0) && scoreboard[rs2_addr_i];
  assign pending_o  = scoreboard;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: vector table for arbitration and write
// port, hand sequences for x0, scoreboard, hold and asynchronous reset.
module tb_regbank_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [2:0]  valid;
  logic [14:0] addr;
  logic [95:0] data;
  logic [2:0]  ready;
  logic        sb_set;
  logic [4:0]  sb_addr;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wr_en;
  logic [4:0]  rd_addr;
  logic [31:0] wdata;
  logic [31:0] pending;

  int checks;
  int errors;

  localparam logic [14:0] A_STD = {5'd11, 5'd7, 5'd3};
  localparam logic [95:0] D_STD = {32'h22220002, 32'hDEADBEEF, 32'hAAAA0000};

  regbank_wb_arbiter #(.N_REQ(3), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold),
    .req_valid_i(valid), .req_addr_i(addr), .req_data_i(data), .req_ready_o(ready),
    .sb_set_i(sb_set), .sb_set_addr_i(sb_addr),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .wr_en_o(wr_en), .rd_addr_o(rd_addr), .data_o(wdata), .pending_o(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hold;
    logic [2:0]  valid;
    logic [2:0]  exp_ready;
    logic        exp_wr;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive all inputs at the falling edge, then settle.
  task automatic drive(input logic h, input logic [2:0] v, input logic [14:0] a,
                       input logic [95:0] d, input logic s, input logic [4:0] sa);
    @(negedge clk);
    hold = h; valid = v; addr = a; data = d; sb_set = s; sb_addr = sa;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; hold = 1'b0; valid = '0; sb_set = 1'b0; sb_addr = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; hold = 1'b0; valid = 3'b111; addr = A_STD; data = D_STD;
    sb_set = 1'b0; sb_addr = '0; rs1 = '0; rs2 = '0;

    // Grant sequence from reset with all three requesters presenting A_STD/D_STD.
    tbl[0]  = '{1'b0, 3'b111, 3'b001, 1'b1, 5'd3,  32'hAAAA0000};
    tbl[1]  = '{1'b0, 3'b111, 3'b010, 1'b1, 5'd7,  32'hDEADBEEF};
    tbl[2]  = '{1'b0, 3'b111, 3'b100, 1'b1, 5'd11, 32'h22220002};
    tbl[3]  = '{1'b0, 3'b111, 3'b001, 1'b1, 5'd3,  32'hAAAA0000};
    tbl[4]  = '{1'b0, 3'b111, 3'b010, 1'b1, 5'd7,  32'hDEADBEEF};
    tbl[5]  = '{1'b0, 3'b111, 3'b100, 1'b1, 5'd11, 32'h22220002};
    tbl[6]  = '{1'b0, 3'b000, 3'b000, 1'b0, 5'd11, 32'h22220002};
    tbl[7]  = '{1'b0, 3'b010, 3'b010, 1'b1, 5'd7,  32'hDEADBEEF};
    tbl[8]  = '{1'b0, 3'b000, 3'b000, 1'b0, 5'd7,  32'hDEADBEEF};
    tbl[9]  = '{1'b0, 3'b101, 3'b100, 1'b1, 5'd11, 32'h22220002};
    tbl[10] = '{1'b0, 3'b101, 3'b001, 1'b1, 5'd3,  32'hAAAA0000};
    tbl[11] = '{1'b0, 3'b101, 3'b100, 1'b1, 5'd11, 32'h22220002};
    tbl[12] = '{1'b1, 3'b001, 3'b000, 1'b0, 5'd11, 32'h22220002};
    tbl[13] = '{1'b0, 3'b110, 3'b010, 1'b1, 5'd7,  32'hDEADBEEF};

    #3;
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_data", wdata, 32'd0);
    chk("reset_pending", pending, 32'd0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].hold, tbl[i].valid, A_STD, D_STD, 1'b0, 5'd0);
      chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(tbl[i].exp_ready));
      tick();
      chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].exp_wr));
      chk($sformatf("vec%0d_rd_addr", i), 32'(rd_addr), 32'(tbl[i].exp_addr));
      chk($sformatf("vec%0d_data", i), wdata, tbl[i].exp_data);
    end

    // x0: accepted and advances rr_ptr, but no bank write and no pending bit.
    do_reset();
    drive(1'b0, 3'b010, A_STD, D_STD, 1'b0, 5'd0);
    tick();
    drive(1'b0, 3'b100, {5'd0, 5'd7, 5'd3}, {32'h1, 32'hDEADBEEF, 32'hAAAA0000}, 1'b1, 5'd0);
    chk("x0_ready", 32'(ready), 32'b100);
    tick();
    chk("x0_wr_en", 32'(wr_en), 32'd0);
    chk("x0_pending", pending, 32'd0);
    drive(1'b0, 3'b011, A_STD, D_STD, 1'b0, 5'd0);
    chk("x0_rr_wrapped", 32'(ready), 32'b001);
    tick();

    // Scoreboard: busy survives the grant cycle, set beats same-cycle clear.
    do_reset();
    drive(1'b0, 3'b000, A_STD, D_STD, 1'b1, 5'd5);
    tick();
    chk("sb_set5", pending, 32'h0000_0020);
    rs1 = 5'd5; rs2 = 5'd0;
    drive(1'b0, 3'b001, {5'd11, 5'd7, 5'd5}, D_STD, 1'b0, 5'd0);
    chk("sb_grant5_ready", 32'(ready), 32'b001);
    chk("sb_busy_same_cycle", 32'(rs1_busy), 32'd1);
    chk("sb_rs2_x0", 32'(rs2_busy), 32'd0);
    tick();
    chk("sb_busy_cleared", 32'(rs1_busy), 32'd0);
    chk("sb_wr5_addr", 32'(rd_addr), 32'd5);
    rs2 = 5'd9;
    drive(1'b0, 3'b010, {5'd11, 5'd9, 5'd5}, D_STD, 1'b1, 5'd9);
    chk("sb_grant9_ready", 32'(ready), 32'b010);
    tick();
    chk("sb_set_wins", pending, 32'h0000_0200);
    chk("sb_rs2_busy9", 32'(rs2_busy), 32'd1);
    chk("sb_wr9_en", 32'(wr_en), 32'd1);
    chk("sb_wr9_addr", 32'(rd_addr), 32'd9);

    // Hold: no grants or writes, set still honoured, rr_ptr preserved.
    do_reset();
    drive(1'b0, 3'b001, A_STD, D_STD, 1'b0, 5'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'b111, A_STD, D_STD, (k == 0), 5'd12);
      chk($sformatf("hold%0d_ready", k), 32'(ready), 32'd0);
      tick();
      chk($sformatf("hold%0d_wr_en", k), 32'(wr_en), 32'd0);
    end
    chk("hold_sb_set12", pending, 32'h0000_1000);
    drive(1'b0, 3'b111, A_STD, D_STD, 1'b0, 5'd0);
    chk("hold_release_ready", 32'(ready), 32'b010);
    tick();
    chk("hold_release_addr", 32'(rd_addr), 32'd7);

    // Asynchronous reset in the middle of a write.
    drive(1'b0, 3'b010, A_STD, D_STD, 1'b1, 5'd20);
    tick();
    chk("mid_wr_en_before", 32'(wr_en), 32'd1);
    chk("mid_pending_before", pending, 32'h0010_1000);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_wr_en_async", 32'(wr_en), 32'd0);
    chk("mid_pending_async", pending, 32'd0);
    chk("mid_ready_async", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
Name: regbank_wb_arbiter

Overview:
Arbitrates write-back requests from N producers (ALU, load unit, CSR unit, ...) onto the single write port of the 32x32 register bank. Uses a round-robin arbiter with per-requester valid/ready handshake, and drives a registered write port with one cycle of latency. Keeps a 32-bit pending-write scoreboard that issue logic sets and granted write-backs clear. Exposes busy flags for the two read addresses so the decode stage can detect RAW hazards.

Parameters:
N_REQ, 3, number of write-back requesters (2..8)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
hold_i  in  1  1 = no grants this cycle (pipeline freeze)
req_valid_i  in  N_REQ  per-requester write-back valid
req_addr_i  in  N_REQ*AW  flattened destination addresses, requester k at bits [k*AW +: AW]
req_data_i  in  N_REQ*DW  flattened write data, requester k at bits [k*DW +: DW]
req_ready_o  out  N_REQ  one-hot grant; combinational
sb_set_i  in  1  issue stage marks a destination as pending
sb_set_addr_i  in  AW  register being marked
rs1_addr_i  in  AW  read address 1 (hazard query)
rs2_addr_i  in  AW  read address 2 (hazard query)
rs1_busy_o  out  1  scoreboard bit of rs1_addr_i; combinational
rs2_busy_o  out  1  scoreboard bit of rs2_addr_i; combinational
wr_en_o  out  1  register bank write enable; registered
rd_addr_o  out  AW  register bank write address; registered
data_o  out  DW  register bank write data; registered
pending_o  out  32  raw scoreboard vector

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_en_o=0, rd_addr_o=0, data_o=0.
  - scoreboard=0, rr_ptr=0.
  - req_ready_o=0 while rst_n=0.
- Handshake: a transfer for requester k occurs in a cycle when req_valid_i[k]=1 and req_ready_o[k]=1.
  - Requesters hold valid, addr and data stable until accepted.
  - req_ready_o never asserts without the matching valid.
- Arbitration, each cycle with hold_i=0:
  - Scan requesters starting at rr_ptr, incrementing mod N_REQ.
  - Grant the first requester with valid=1; at most one grant per cycle.
  - After a grant to k, rr_ptr <= (k+1) mod N_REQ.
  - With no grant, rr_ptr is unchanged.
- hold_i=1: req_ready_o=0, wr_en_o<=0 next edge, rr_ptr and scoreboard clear path frozen. sb_set_i is still honoured.
- Write port, one-cycle latency:
  - On the edge after a transfer: wr_en_o<=1, rd_addr_o<=granted addr, data_o<=granted data.
  - Otherwise wr_en_o<=0; rd_addr_o and data_o hold their last values.
- Register x0:
  - A request to address 0 is accepted normally (ready asserted, rr_ptr advances), but wr_en_o stays 0 for it.
  - The scoreboard never sets bit 0; sb_set_i with address 0 is ignored.
- Scoreboard update at each edge:
  - Clear the bit of the granted address (on the transfer cycle).
  - Set the bit for sb_set_i.
  - Set and clear on the same register in the same cycle: set wins (a newer producer is in flight).
  - Set on an already-set bit: remains 1, no error.
- Busy outputs:
  - rs1_busy_o and rs2_busy_o reflect the current scoreboard register only.
  - A same-cycle grant does not clear them; they drop on the edge after the grant.
  - Address 0 always reads 0.
- Reset mid-operation: all state cleared immediately; an in-flight wr_en_o drops asynchronously; the lost write is not replayed.
- Widths: index arithmetic is on ceil(log2(N_REQ))-bit rr_ptr; wrap from N_REQ-1 to 0 must be explicit (N_REQ need not be a power of two).

Test Plan:
- Reset: drive rst_n=0 mid-write (wr_en_o=1) -> wr_en_o, pending_o and req_ready_o go to 0 without a clock edge.
- Single request: req_valid_i=3'b010, addr=5'd7, data=32'hDEADBEEF -> req_ready_o=3'b010 the same cycle; next edge wr_en_o=1, rd_addr_o=7, data_o=32'hDEADBEEF; following cycle wr_en_o=0.
- Round-robin fairness: all three valid for 6 cycles from reset -> grants 0,1,2,0,1,2; writes appear at the bank one cycle later, in the same order.
- x0 suppression: requester 2 writes addr 0, data 32'h1 -> ready=3'b100, rr_ptr becomes 0, wr_en_o stays 0. Separately, sb_set_i with address 0 -> pending_o[0] stays 0.
- Scoreboard hazard: sb_set_i addr 5 -> next cycle rs1_addr_i=5 gives rs1_busy_o=1. Grant a write to 5 -> rs1_busy_o is still 1 that cycle and 0 after the edge. Set and grant on 9 in the same cycle -> pending_o[9]=1 afterwards.
- Hold: valid=3'b111 with hold_i=1 for 3 cycles -> req_ready_o=0 and wr_en_o=0 throughout; sb_set_i addr 12 still sets bit 12. On release, the grant goes to the requester at the preserved rr_ptr.
